// File: rtl/twobtn_led_ctrl_pkg.sv
// Shared types for the two-button LED controller: ownership states and LED patterns.
package twobtn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BLUE = 2'd1,
        RED  = 2'd2,
        BOTH = 2'd3
    } state_t;

    // Patterns are written led[0],led[1]: blue LED first.
    localparam logic [0:1] LED_OFF  = 2'b00;
    localparam logic [0:1] LED_BLUE = 2'b10;
    localparam logic [0:1] LED_RED  = 2'b01;

endpackage

// File: rtl/twobtn_led_ctrl_if.sv
// Pin-side bundle: raw active-low buttons in, LED pair and ownership state out.
interface twobtn_led_ctrl_if;
    import twobtn_pkg::*;

    logic       bluebtn;
    logic       redbtn;
    logic [0:1] led;
    state_t     state;

    modport master (output bluebtn, redbtn, input led, state);
    modport slave  (input bluebtn, redbtn, output led, state);

endinterface

// File: rtl/twobtn_led_ctrl_btn_debounce.sv
// 2-flop synchronizer plus counting debouncer; emits a one-cycle pulse on an accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= 2'b11;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync  <= {sync[0], btn_raw};
            press <= 1'b0;
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync[1];
                cnt    <= '0;
                // Only the released->pressed direction (pin going low) is a request.
                press  <= ~sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/twobtn_led_ctrl.sv
// Two-button LED ownership arbiter with blink in BOTH.
// Optional idle-ownership timeout enabled by defining TWOBTN_TIMEOUT_EN.
module twobtn_led_ctrl
    import twobtn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_CYCLES    = 12500000,
    parameter int TIMEOUT_CYCLES  = 250000000
) (
    input  logic               clk,
    input  logic               rst_n,
    twobtn_led_ctrl_if.slave   io
);

    localparam int BW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    state_t        state, state_nxt;
    logic          pb, pr, timeout;
    logic          phase;
    logic [BW-1:0] bcnt;
    logic [0:1]    led, led_nxt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_blue (
        .clk(clk), .rst_n(rst_n), .btn_raw(io.bluebtn), .press(pb)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_red (
        .clk(clk), .rst_n(rst_n), .btn_raw(io.redbtn), .press(pr)
    );

`ifdef TWOBTN_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tcnt;

    assign timeout = (state != IDLE) && (tcnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tcnt <= '0;
        else if (pb || pr || (state_nxt != state))
            tcnt <= '0;
        else if (state != IDLE)
            tcnt <= tcnt + 1'b1;
    end
`else
    // Ownership is held indefinitely in this build.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Press pulses always win over the timeout.
    always_comb begin
        state_nxt = state;
        case ({pb, pr})
            2'b11:   state_nxt = (state == BOTH) ? IDLE : BOTH;
            2'b10:   state_nxt = (state == IDLE || state == RED)  ? BLUE : IDLE;
            2'b01:   state_nxt = (state == IDLE || state == BLUE) ? RED  : IDLE;
            default: if (timeout) state_nxt = IDLE;
        endcase
    end

    always_comb begin
        led_nxt = LED_OFF;
        case (state)
            BLUE:    led_nxt = LED_BLUE;
            RED:     led_nxt = LED_RED;
            BOTH:    led_nxt = {phase, ~phase};
            default: led_nxt = LED_OFF;
        endcase
    end

    // Entry into BOTH restarts the blink so the first pattern shown is blue-on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (state_nxt == BOTH && state != BOTH) begin
            bcnt  <= '0;
            phase <= 1'b1;
        end else if (state == BOTH) begin
            if (bcnt == BLINK_LAST) begin
                bcnt  <= '0;
                phase <= ~phase;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) led <= LED_OFF;
        else        led <= led_nxt;
    end

    assign io.led   = led;
    assign io.state = state;

endmodule

// File: tb/tb_twobtn_led_ctrl.sv
// Bench for twobtn_led_ctrl: directed scenarios plus random pin activity against a reference model.
module tb_twobtn_led_ctrl;

    localparam int DEB = 4;
    localparam int BL  = 3;
    localparam int TO  = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    twobtn_led_ctrl_if io();

    twobtn_led_ctrl #(
        .DEBOUNCE_CYCLES(DEB), .BLINK_CYCLES(BL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .io(io)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Per-edge view: a button's filtered level changes once the pin (seen two
    // edges late) has disagreed with it for DEB consecutive edges; the press
    // request is acted on by the ownership rules at the following edge.
    logic [1:0] m_state;
    logic [0:1] m_led;
    bit         qb[$], qr[$];
    bit         st_b, st_r, pend_b, pend_r;
    int         run_b, run_r;
    int         cyc, last_evt, both_entry;

    task automatic model_reset();
        m_state = 2'd0; m_led = 2'b00;
        qb = '{1'b1, 1'b1}; qr = '{1'b1, 1'b1};
        st_b = 1'b1; st_r = 1'b1; pend_b = 1'b0; pend_r = 1'b0;
        run_b = 0; run_r = 0; cyc = 0; last_evt = 0; both_entry = 0;
    endtask

    task automatic deb_step(input bit seen, inout bit st, inout int run, output bit pulse);
        pulse = 1'b0;
        if (seen != st) begin
            run++;
            if (run == DEB) begin
                st = seen; run = 0; pulse = (seen == 1'b0);
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic model_step();
        logic [1:0] old;
        bit         sb, sr;
        int         j;
        cyc++;
        old = m_state;
        if (pend_b && pend_r)  m_state = (old == 2'd3) ? 2'd0 : 2'd3;
        else if (pend_b)       m_state = (old == 2'd1 || old == 2'd3) ? 2'd0 : 2'd1;
        else if (pend_r)       m_state = (old == 2'd2 || old == 2'd3) ? 2'd0 : 2'd2;
`ifdef TWOBTN_TIMEOUT_EN
        else if (old != 2'd0 && (cyc - last_evt) == TO) m_state = 2'd0;
`endif
        case (old)
            2'd1: m_led = 2'b10;
            2'd2: m_led = 2'b01;
            2'd3: begin
                j = cyc - 1 - both_entry;
                m_led = ((j / BL) % 2 == 0) ? 2'b10 : 2'b01;
            end
            default: m_led = 2'b00;
        endcase
        if (m_state != old || pend_b || pend_r) last_evt = cyc;
        if (m_state == 2'd3 && old != 2'd3) both_entry = cyc;
        qb.push_back(io.bluebtn); sb = qb[0]; void'(qb.pop_front());
        qr.push_back(io.redbtn);  sr = qr[0]; void'(qr.pop_front());
        deb_step(sb, st_b, run_b, pend_b);
        deb_step(sr, st_r, run_r, pend_r);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic do_reset();
        @(negedge clk);
        io.bluebtn = 1'b1; io.redbtn = 1'b1; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        io.bluebtn = 1'b0; io.redbtn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            io.bluebtn = 1'($urandom); io.redbtn = 1'($urandom);
            n_checks++;
            if (io.led !== 2'b00 || io.state !== 2'd0)
                $display("FAIL reset_hold: led=%b state=%0d want led=00 state=0", io.led, io.state);
            else n_pass++;
        end
        io.bluebtn = 1'b1; io.redbtn = 1'b1; rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n_checks++;
            if (io.led !== 2'b00 || io.state !== 2'd0 || io.state !== m_state)
                $display("FAIL reset_idle: led=%b state=%0d want led=00 state=0", io.led, io.state);
            else n_pass++;
        end
    endtask

    task automatic test_blue_press();
        @(negedge clk); io.bluebtn = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (io.state !== 2'd0) $display("FAIL blue_early: state=%0d want 0", io.state);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (io.state !== 2'd1) $display("FAIL blue_state: state=%0d want 1", io.state);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (io.led !== 2'b10) $display("FAIL blue_led: led=%b want 10", io.led);
        else n_pass++;
        io.bluebtn = 1'b1;
        repeat (7) @(negedge clk);
        io.bluebtn = 1'b0;
        repeat (7) @(negedge clk);
        n_checks++;
        if (io.state !== 2'd0) $display("FAIL blue_second_state: state=%0d want 0", io.state);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (io.led !== 2'b00) $display("FAIL blue_second_led: led=%b want 00", io.led);
        else n_pass++;
        io.bluebtn = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            io.bluebtn = (i < 30) ? 1'((i / 2) % 2) : 1'b1;
            n_checks++;
            if (io.state !== 2'd0 || io.led !== 2'b00)
                $display("FAIL bounce: state=%0d led=%b want state=0 led=00", io.state, io.led);
            else n_pass++;
        end
    endtask

    task automatic test_preempt();
        @(negedge clk); io.bluebtn = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (io.led !== 2'b10) $display("FAIL preempt_blue: led=%b want 10", io.led);
        else n_pass++;
        io.redbtn = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (io.led !== 2'b01 || io.state !== 2'd2)
            $display("FAIL preempt_red: led=%b state=%0d want led=01 state=2", io.led, io.state);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_simultaneous();
        logic [0:1] seq [7] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};
        @(negedge clk); io.bluebtn = 1'b0; io.redbtn = 1'b0;
        repeat (7) @(negedge clk);
        n_checks++;
        if (io.state !== 2'd3) $display("FAIL simul_state: state=%0d want 3", io.state);
        else n_pass++;
        io.redbtn = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            n_checks++;
            if (io.led !== seq[i]) $display("FAIL simul_blink[%0d]: led=%b want %b", i, io.led, seq[i]);
            else n_pass++;
        end
        io.redbtn = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (io.led !== 2'b00 || io.state !== 2'd0)
            $display("FAIL simul_red_exit: led=%b state=%0d want led=00 state=0", io.led, io.state);
        else n_pass++;
        do_reset();
    endtask

`ifdef TWOBTN_TIMEOUT_EN
    task automatic test_timeout();
        int on_cnt;
        @(negedge clk); io.redbtn = 1'b0;
        repeat (7) @(negedge clk);
        n_checks++;
        if (io.state !== 2'd2) $display("FAIL timeout_enter: state=%0d want 2", io.state);
        else n_pass++;
        on_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (io.led === 2'b01) on_cnt++;
        end
        n_checks++;
        if (on_cnt != 20) $display("FAIL timeout_span: led=01 cycles=%0d want 20", on_cnt);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (io.led !== 2'b00 || io.state !== 2'd0)
            $display("FAIL timeout_expire: led=%b state=%0d want led=00 state=0", io.led, io.state);
        else n_pass++;
        io.redbtn = 1'b1;
        repeat (8) @(negedge clk);
        io.redbtn = 1'b0;
        repeat (7) @(negedge clk);
        repeat (13) @(negedge clk);
        io.bluebtn = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (io.state !== 2'd2) $display("FAIL timeout_race_pre: state=%0d want 2", io.state);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (io.state !== 2'd1) $display("FAIL timeout_race: state=%0d want 1", io.state);
        else n_pass++;
        do_reset();
    endtask
`else
    task automatic test_hold();
        @(negedge clk); io.redbtn = 1'b0;
        repeat (8) @(negedge clk);
        repeat (40) @(negedge clk);
        n_checks++;
        if (io.state !== 2'd2 || io.led !== 2'b01)
            $display("FAIL hold_no_timeout: state=%0d led=%b want state=2 led=01", io.state, io.led);
        else n_pass++;
        do_reset();
    endtask
`endif

    task automatic test_reset_mid();
        @(negedge clk); io.bluebtn = 1'b0;
        repeat (8) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (io.state !== 2'd0 || io.led !== 2'b00)
            $display("FAIL reset_async: state=%0d led=%b want state=0 led=00", io.state, io.led);
        else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++;
        if (io.state !== 2'd0) $display("FAIL reset_held_early: state=%0d want 0", io.state);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (io.state !== 2'd1) $display("FAIL reset_held_accept: state=%0d want 1", io.state);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_random();
        int hold_b = 0, hold_r = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            n_checks++;
            if (io.state !== m_state || io.led !== m_led)
                $display("FAIL random[%0d]: state=%0d led=%b want state=%0d led=%b",
                         i, io.state, io.led, m_state, m_led);
            else n_pass++;
            if (hold_b == 0) begin io.bluebtn = 1'($urandom); hold_b = $urandom_range(1, 9); end
            else hold_b--;
            if (hold_r == 0) begin io.redbtn = 1'($urandom); hold_r = $urandom_range(1, 9); end
            else hold_r--;
        end
    endtask

    initial begin
        io.bluebtn = 1'b1; io.redbtn = 1'b1;
        test_reset();
        test_blue_press();
        test_bounce();
        test_preempt();
        test_simultaneous();
`ifdef TWOBTN_TIMEOUT_EN
        test_timeout();
`else
        test_hold();
`endif
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/twobtn_led_ctrl.md
# twobtn_led_ctrl

Controller that shares the board's two-LED display between the blue and red pushbuttons. Raw button pins are synchronized and debounced, and each press becomes a one-cycle request. A small ownership state machine arbitrates the requests and drives the LED pair. It sits between the top-level button/LED pins and replaces direct pin-to-LED wiring.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronized samples needed to accept a level change (10 ms at 50 MHz); minimum 2.
- BLINK_CYCLES, 12500000: cycles per blink half-period in BOTH; minimum 2.
- TIMEOUT_CYCLES, 250000000: idle-ownership timeout (only with TWOBTN_TIMEOUT_EN); minimum 2.
- clk  in  1  system clock, single domain.
- rst_n  in  1  asynchronous, active-low reset.
- bluebtn  in  1  raw blue button pin, active-low (pressed = 0), asynchronous to clk.
- redbtn  in  1  raw red button pin, active-low, asynchronous to clk.
- led  out  [0:1]  led[0] = blue LED, led[1] = red LED, active-high, registered.
- state  out  2  current ownership state encoding, for debug and visibility.

## Operation
- Each button has a 2-flop synchronizer, then a debouncer.
  - The debounce counter clears on any cycle where the synchronized level equals the stable level.
  - While the two levels differ, the counter increments.
  - When the count reaches DEBOUNCE_CYCLES-1 with the levels still differing, the stable level is updated and the counter clears.
- A press pulse (1 cycle) fires when the stable level goes released to pressed. Releases generate nothing.
- States: IDLE=0, BLUE=1, RED=2, BOTH=3.
- Transitions, evaluated on press pulses pb (blue) and pr (red):
  - pb & pr in IDLE, BLUE or RED -> BOTH.
  - pb & pr in BOTH -> IDLE.
  - pb alone: IDLE -> BLUE; BLUE -> IDLE; RED -> BLUE (preemption); BOTH -> IDLE.
  - pr alone: IDLE -> RED; RED -> IDLE; BLUE -> RED; BOTH -> IDLE.
  - No pulse: hold, except on timeout.
- LED decode, registered from the state register:
  - IDLE: 00.
  - BLUE: led[0]=1, led[1]=0.
  - RED: led[0]=0, led[1]=1.
  - BOTH: led[0]=phase, led[1]=~phase.
- Blink counter runs 0..BLINK_CYCLES-1. Phase toggles on wrap.
- On entry to BOTH, the counter clears and phase is set to 1, so the first displayed pattern is led=10.

## Timing
- Reset values: led=00, state=IDLE, synchronizers and stable levels = released (1), all counters 0, phase 0. There are no press pulses out of reset.
- Latency:
  - A pin edge held stable yields a press pulse 2 (sync) + DEBOUNCE_CYCLES cycles later.
  - state updates on the cycle after the pulse; led updates one cycle after state.
- Pulses from the two buttons in the same cycle count as simultaneous. Pulses one cycle apart count as two single presses, in order.
- Bounce shorter than DEBOUNCE_CYCLES produces no pulse and no state change.
- Asserting reset mid-operation forces all reset values immediately, regardless of clock. A button held through reset deassertion still has to pass the full debounce before it is accepted.
- The blink counter only advances in BOTH. Leaving BOTH freezes the counter, and its value is irrelevant until the next entry.

## Configuration
- TWOBTN_TIMEOUT_EN defined:
  - A timeout counter clears on every press pulse and on every state change, and increments in BLUE, RED and BOTH.
  - At TIMEOUT_CYCLES-1 the state goes to IDLE on the next cycle.
  - A press pulse in the same cycle as timeout takes priority, and the normal transition applies.
- TWOBTN_TIMEOUT_EN undefined: no timeout counter is built, TIMEOUT_CYCLES is ignored, and ownership is held indefinitely.

## Structure
- twobtn_pkg holds:
  - the state enum and its encodings (IDLE/BLUE/RED/BOTH);
  - the LED pattern constants LED_OFF=00, LED_BLUE=10, LED_RED=01, where bit 0 is written first (led[0],led[1]).
- One sub-module, btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst_n, btn_raw, press). It is instantiated twice.
- The arbiter FSM, blink counter, timeout counter and LED register stay in twobtn_led_ctrl.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, BLINK_CYCLES=3, TIMEOUT_CYCLES=20.
- Reset: rst_n low with buttons bouncing -> led=00, state=0 throughout. After release with both buttons held at 1 for 50 cycles -> no change.
- Clean blue press: bluebtn held at 0 -> state=1 at pin edge + 7 cycles, led=10 one cycle later. A second press -> led=00.
- Bounce rejection: bluebtn toggled every 2 cycles for 30 cycles, then held at 1 -> state stays 0.
- Preemption: blue press then red press -> led goes 10 then 01.
- Simultaneous: both pins go 0 in the same cycle -> state=3, led sequence 10,10,10,01,01,01,10…. Then a red-only press -> led=00.
- Timeout (TWOBTN_TIMEOUT_EN): red press, then no activity -> led=01 for exactly 20 cycles after the state change, then 00.
- Timeout (TWOBTN_TIMEOUT_EN): a blue press landing on the timeout cycle -> state=1, not 0.
